// File: rtl/bus_mux_keeper.sv
// -----------------------------------------------------------------------------
// bus_mux_keeper
//
// Drives one of NUM_SRC source words onto the shared CPU bus. Sources are
// selected by per-source "out" enables that are meant to be one-hot. When
// more than one enable is set, the highest-index source wins and the cycle
// is flagged as a conflict. When no enable is set, a keeper register holds
// the last value that was driven, so the bus never floats.
//
// Source index map: 0..15 = R0..R15, 16 = HI, 17 = LO, 18 = Y, 19 = Zhigh,
// 20 = Zlow, 21 = PC, 22 = MDR, 23 = InPort, 24 = Csignextended.
//
// Parameters:
//   WIDTH      bus / source word width
//   NUM_SRC    number of bus sources
//   REGISTERED 0 = combinational bus path, 1 = bus_out registered (1 cycle)
//   CNT_W      width of the saturating conflict counter
//
// Ports:
//   clock           system clock, rising edge
//   clear           asynchronous active-low reset
//   src_data        flattened source words, source i at [i*WIDTH +: WIDTH]
//   src_out         per-source drive enables
//   err_clr         synchronous clear of conflict_sticky / conflict_count
//   bus_out         bus value
//   bus_valid       a source drives bus_out this cycle
//   active_src      index of the winning (or last winning) source
//   conflict        two or more enables set this cycle (combinational)
//   conflict_sticky latched conflict indicator
//   conflict_count  saturating count of conflict cycles
// -----------------------------------------------------------------------------
module bus_mux_keeper #(
    parameter int WIDTH      = 32,
    parameter int NUM_SRC    = 25,
    parameter int REGISTERED = 0,
    parameter int CNT_W      = 8,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_out,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic [SRC_W-1:0]         active_src,
    output logic                     conflict,
    output logic                     conflict_sticky,
    output logic [CNT_W-1:0]         conflict_count
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic               w_sel_any;
    logic               w_multi;
    logic [SRC_W-1:0]   w_win_idx;
    logic [WIDTH-1:0]   w_sel_data;

    logic [WIDTH-1:0]   r_keep;
    logic [SRC_W-1:0]   r_active;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_count;

    // Ascending scan: a later (higher-index) enable overwrites an earlier
    // one, giving highest-index priority. A second hit marks a conflict.
    always_comb begin
        w_sel_any  = 1'b0;
        w_multi    = 1'b0;
        w_win_idx  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_out[i]) begin
                w_multi    = w_multi | w_sel_any;
                w_sel_any  = 1'b1;
                w_win_idx  = SRC_W'(i);
                w_sel_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign conflict = w_multi;

    // Keeper and winner index only load while someone actually drives.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_keep   <= '0;
            r_active <= '0;
        end else if (w_sel_any) begin
            r_keep   <= w_sel_data;
            r_active <= w_win_idx;
        end
    end

    // A new conflict takes priority over a clear landing in the same cycle,
    // so no conflict event is ever lost.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_multi) begin
                r_sticky <= 1'b1;
            end else if (err_clr) begin
                r_sticky <= 1'b0;
            end

            if (err_clr) begin
                r_count <= w_multi ? CNT_W'(1) : '0;
            end else if (w_multi) begin
                r_count <= sat_inc(r_count);
            end
        end
    end

    assign conflict_sticky = r_sticky;
    assign conflict_count  = r_count;

    generate
        if (REGISTERED != 0) begin : g_reg
            logic r_valid;

            always_ff @(posedge clock or negedge clear) begin
                if (!clear) begin
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_sel_any;
                end
            end

            // Keeper doubles as the output register.
            assign bus_out    = r_keep;
            assign bus_valid  = r_valid;
            assign active_src = r_active;
        end else begin : g_comb
            // Live selection passes straight through; the keeper only fills
            // in when nobody drives.
            assign bus_out    = w_sel_any ? w_sel_data : r_keep;
            assign bus_valid  = w_sel_any;
            assign active_src = w_sel_any ? w_win_idx : r_active;
        end
    endgenerate

endmodule

// File: tb/tb_bus_mux_keeper.sv
module tb_bus_mux_keeper;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 25;
    localparam int SRC_W   = 5;
    localparam int MAX8    = 255;
    localparam int MAX2    = 3;

    logic                     clock;
    logic                     clear;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_out;
    logic                     err_clr;

    logic [WIDTH-1:0] c_bus;
    logic             c_vld;
    logic [SRC_W-1:0] c_act;
    logic             c_conf;
    logic             c_sticky;
    logic [7:0]       c_cnt;

    logic [WIDTH-1:0] r_bus;
    logic             r_vld;
    logic [SRC_W-1:0] r_act;
    logic             r_conf;
    logic             r_sticky;
    logic [1:0]       r_cnt;

    bus_mux_keeper #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .REGISTERED(0), .CNT_W(8)) dut_c (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
        .err_clr(err_clr), .bus_out(c_bus), .bus_valid(c_vld), .active_src(c_act),
        .conflict(c_conf), .conflict_sticky(c_sticky), .conflict_count(c_cnt));

    bus_mux_keeper #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .REGISTERED(1), .CNT_W(2)) dut_r (
        .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out),
        .err_clr(err_clr), .bus_out(r_bus), .bus_valid(r_vld), .active_src(r_act),
        .conflict(r_conf), .conflict_sticky(r_sticky), .conflict_count(r_cnt));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference state: what the bus "remembers" and the debug counters.
    logic [WIDTH-1:0] m_keep;
    int               m_act;
    bit               m_vld;
    bit               m_sticky;
    int               m_cnt8;
    int               m_cnt2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] word(input int i);
        return src_data[i*WIDTH +: WIDTH];
    endfunction

    // Highest asserted enable, or -1 when none.
    function automatic int winner();
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_out[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit is_conflict();
        return $countones(src_out) >= 2;
    endfunction

    task automatic model_reset();
        m_keep   = '0;
        m_act    = 0;
        m_vld    = 0;
        m_sticky = 0;
        m_cnt8   = 0;
        m_cnt2   = 0;
    endtask

    task automatic model_edge();
        int w;
        bit cf;
        if (!clear) begin
            model_reset();
            return;
        end
        w  = winner();
        cf = is_conflict();
        if (w >= 0) begin
            m_keep = word(w);
            m_act  = w;
        end
        m_vld = (w >= 0);
        if (cf) m_sticky = 1;
        else if (err_clr) m_sticky = 0;
        if (err_clr) begin
            m_cnt8 = cf ? 1 : 0;
            m_cnt2 = cf ? 1 : 0;
        end else if (cf) begin
            m_cnt8 = (m_cnt8 < MAX8) ? m_cnt8 + 1 : MAX8;
            m_cnt2 = (m_cnt2 < MAX2) ? m_cnt2 + 1 : MAX2;
        end
    endtask

    task automatic check_all(input string tag);
        int w;
        bit any;
        w   = winner();
        any = (w >= 0);
        chk({tag, ":c_bus"},    64'(c_bus),    any ? 64'(word(w)) : 64'(m_keep));
        chk({tag, ":c_vld"},    64'(c_vld),    64'(any));
        chk({tag, ":c_act"},    64'(c_act),    any ? 64'(w) : 64'(m_act));
        chk({tag, ":c_conf"},   64'(c_conf),   64'(is_conflict()));
        chk({tag, ":c_sticky"}, 64'(c_sticky), 64'(m_sticky));
        chk({tag, ":c_cnt"},    64'(c_cnt),    64'(m_cnt8));
        chk({tag, ":r_bus"},    64'(r_bus),    64'(m_keep));
        chk({tag, ":r_vld"},    64'(r_vld),    64'(m_vld));
        chk({tag, ":r_act"},    64'(r_act),    64'(m_act));
        chk({tag, ":r_conf"},   64'(r_conf),   64'(is_conflict()));
        chk({tag, ":r_sticky"}, 64'(r_sticky), 64'(m_sticky));
        chk({tag, ":r_cnt"},    64'(r_cnt),    64'(m_cnt2));
    endtask

    // Check before the edge, clock, update the model, check after the edge.
    task automatic cycle(input string tag);
        #1;
        check_all({tag, "_pre"});
        @(posedge clock);
        model_edge();
        #1;
        check_all({tag, "_post"});
    endtask

    task automatic set_word(input int i, input logic [WIDTH-1:0] v);
        src_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic async_pulse(input string tag);
        #2;
        clear = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ":r_cnt0"}, 64'(r_cnt), 64'd0);
        chk({tag, ":r_bus0"}, 64'(r_bus), 64'd0);
        clear = 1'b1;
    endtask

    int exp_sat2 [5] = '{1, 2, 3, 3, 3};
    int pick;

    initial begin
        // Reset then idle
        clear    = 1'b0;
        src_out  = '0;
        src_data = '0;
        err_clr  = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        cycle("in_reset");
        chk("reset_bus", 64'(c_bus), 64'd0);
        clear = 1'b1;
        cycle("idle1");
        cycle("idle2");
        chk("idle_cnt", 64'(c_cnt), 64'd0);

        // Single driver: PC
        set_word(21, 32'h0000_0010);
        src_out = 25'(1) << 21;
        cycle("pc");
        chk("pc_bus",  64'(c_bus), 64'h10);
        chk("pc_act",  64'(c_act), 64'd21);
        chk("pc_vld",  64'(c_vld), 64'd1);
        chk("pc_rbus", 64'(r_bus), 64'h10);
        src_out = '0;
        cycle("pc_hold");
        chk("pc_hold_bus", 64'(c_bus), 64'h10);
        chk("pc_hold_vld", 64'(c_vld), 64'd0);

        // Registered latency: MDR for one cycle
        set_word(22, 32'hDEAD_BEEF);
        src_out = 25'(1) << 22;
        cycle("mdr");
        chk("mdr_rbus", 64'(r_bus), 64'hDEADBEEF);
        chk("mdr_rvld", 64'(r_vld), 64'd1);
        src_out = '0;
        cycle("mdr_hold");
        chk("mdr_hold_rvld", 64'(r_vld), 64'd0);
        chk("mdr_hold_rbus", 64'(r_bus), 64'hDEADBEEF);

        // Conflict priority: R2 and R7
        set_word(2, 32'h2);
        set_word(7, 32'h7);
        src_out = (25'(1) << 2) | (25'(1) << 7);
        cycle("conf");
        chk("conf_bus",    64'(c_bus),    64'h7);
        chk("conf_act",    64'(c_act),    64'd7);
        chk("conf_flag",   64'(c_conf),   64'd1);
        chk("conf_sticky", 64'(c_sticky), 64'd1);
        chk("conf_cnt",    64'(c_cnt),    64'd1);

        // Clear, then saturate the 2-bit counter
        src_out = '0;
        err_clr = 1'b1;
        cycle("clr0");
        err_clr = 1'b0;
        src_out = (25'(1) << 2) | (25'(1) << 7);
        for (int k = 0; k < 5; k++) begin
            cycle("sat");
            chk("sat_cnt2", 64'(r_cnt), 64'(exp_sat2[k]));
            chk("sat_cnt8", 64'(c_cnt), 64'(k + 1));
        end
        err_clr = 1'b1;
        cycle("clr_conf");
        chk("clr_conf_cnt",    64'(r_cnt),    64'd1);
        chk("clr_conf_sticky", 64'(r_sticky), 64'd1);
        src_out = '0;
        cycle("clr_only");
        chk("clr_only_cnt",    64'(r_cnt),    64'd0);
        chk("clr_only_sticky", 64'(r_sticky), 64'd0);
        err_clr = 1'b0;

        // Async reset mid-operation
        set_word(24, 32'hFFFF_FFFF);
        set_word(3, 32'h3);
        src_out = (25'(1) << 24) | (25'(1) << 3);
        cycle("pre_async1");
        cycle("pre_async2");
        chk("pre_async_cnt",  64'(r_cnt), 64'd2);
        chk("pre_async_keep", 64'(r_bus), 64'hFFFFFFFF);
        src_out = '0;
        async_pulse("async");
        cycle("after_async");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int s = 0; s < NUM_SRC; s++) set_word(s, $urandom);
            pick = $urandom_range(0, 9);
            if (pick < 3) src_out = '0;
            else if (pick < 8) src_out = 25'(1) << $urandom_range(0, NUM_SRC - 1);
            else src_out = 25'($urandom);
            err_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) async_pulse("rnd_async");
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
